// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared funct3 codes and MEM-stage FSM encoding
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size lives in funct3[1:0]; 2'b11 has no RV32I meaning.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // True when the low address bits do not fit the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = addr_lo[0];
            SZ_W:    is_misaligned = |addr_lo;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - picks the addressed byte/half from a read word and extends it
module mem_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by sign or zero extension chosen by funct3.
    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    ReadData = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ReadData = {24'h0, byte_sel};
            F3_H:    ReadData = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ReadData = {16'h0, half_sel};
            F3_W:    ReadData = rdata;
            default: ReadData = 32'h0;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RV32I MEM stage: data bus handshake, store steering, MEM/WB register
module memory_cycle
    import riscv_mem_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        LoadM,
    input  logic        StoreM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] InstrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] InstrW,
    output logic        MisalignW,
    output logic        MemErrW
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    mem_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        mem_op;
    logic        misalign;
    logic        access;
    logic        req;
    logic        stall;
    logic        abort;
    logic [31:0] load_data;

    assign funct3   = InstrM[14:12];
    assign addr_lo  = ALU_ResultM[1:0];
    assign mem_op   = LoadM | StoreM;
    assign misalign = is_misaligned(funct3[1:0], addr_lo);
    assign access   = mem_op & ~misalign;

    // Reset gates the bus request and stall so they drop the instant rst rises.
    assign dmem_req  = req & ~rst;
    assign StallM    = stall & ~rst;
    assign dmem_we   = StoreM;
    assign dmem_addr = {ALU_ResultM[31:2], 2'b00};

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Handshake sequencing: complete on ready, stall while waiting, abort at the limit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req     = 1'b0;
        stall   = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (!dmem_ready) begin
                        stall   = 1'b1;
                        state_n = WAIT;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!access) begin
                    // EX/MEM is held while stalled, so this only guards odd upstream behaviour.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (dmem_ready) begin
                    req     = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt < LIMIT) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    cnt_n = cnt + 1'b1;
                end else begin
                    abort   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Store lane steering: replicate the datum across lanes and enable only the addressed bytes.
    always_comb begin
        dmem_wdata = WriteDataM;
        dmem_be    = 4'b1111;
        if (StoreM) begin
            case (funct3[1:0])
                SZ_B: begin
                    dmem_wdata = {4{WriteDataM[7:0]}};
                    dmem_be    = 4'b0001 << addr_lo;
                end
                SZ_H: begin
                    dmem_wdata = {2{WriteDataM[15:0]}};
                    dmem_be    = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    dmem_wdata = WriteDataM;
                    dmem_be    = 4'b1111;
                end
            endcase
        end
    end

    mem_load_align u_load_align (
        .rdata    (dmem_rdata),
        .addr     (addr_lo),
        .funct3   (funct3),
        .ReadData (load_data)
    );

    // MEM/WB register: bubble while stalled, otherwise capture the finished instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'h0;
            ALU_ResultW <= 32'h0;
            ReadDataW   <= 32'h0;
            InstrW      <= 32'h0;
            MisalignW   <= 1'b0;
            MemErrW     <= 1'b0;
        end else if (stall) begin
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
            MemErrW   <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~(mem_op & misalign) & ~abort;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (LoadM & access & ~abort) ? load_data : 32'h0;
            InstrW      <= InstrM;
            MisalignW   <= mem_op & misalign;
            MemErrW     <= abort;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - scoreboard bench for the MEM stage
module tb_memory_cycle;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, LoadM, StoreM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, InstrM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM, RegWriteW, MisalignW, MemErrW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, InstrW;

    memory_cycle #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadM(LoadM), .StoreM(StoreM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM), .InstrM(InstrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .InstrW(InstrW), .MisalignW(MisalignW), .MemErrW(MemErrW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bubble;
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] instr;
        logic        mis;
        logic        err;
    } wb_t;

    wb_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc       = 32'h1000;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference load: shift the addressed item down to bit 0, then mask and extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * addr[1:0]);
        case (f3)
            3'b000:  return sh[7] ? (sh | 32'hFFFF_FF00) : (sh & 32'hFF);
            3'b100:  return sh & 32'hFF;
            3'b001:  return sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'hFFFF);
            3'b101:  return sh & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] addr);
        int size;
        if (f3[1:0] == 2'b11) return 1'b1;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] m;
        if (!st) return 4'hF;
        m = (f3[1:0] == 2'b00) ? 4'h1 : (f3[1:0] == 2'b01) ? 4'h3 : 4'hF;
        if (f3[1:0] == 2'b01) return m << (addr[1] ? 2 : 0);
        if (f3[1:0] == 2'b00) return m << addr[1:0];
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic st, input logic [2:0] f3, input logic [31:0] d);
        if (st && f3[1:0] == 2'b00) return d[7:0] * 32'h0101_0101;
        if (st && f3[1:0] == 2'b01) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    task automatic compare_wb();
        wb_t e;
        if (sb.size() == 0) begin
            check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("RegWriteW", 32'(RegWriteW), 32'(e.rw));
        check_eq("MisalignW", 32'(MisalignW), 32'(e.mis));
        check_eq("MemErrW",   32'(MemErrW),   32'(e.err));
        if (!e.bubble) begin
            check_eq("ResultSrcW",  32'(ResultSrcW), 32'(e.rs));
            check_eq("RD_W",        32'(RD_W),       32'(e.rd));
            check_eq("PCPlus4W",    PCPlus4W,        e.pc4);
            check_eq("ALU_ResultW", ALU_ResultW,     e.alu);
            check_eq("ReadDataW",   ReadDataW,       e.rdata);
            check_eq("InstrW",      InstrW,          e.instr);
        end
    endtask

    // Drive one EX/MEM instruction; memory answers after w cycles (never if w is large).
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdat, input int w);
        logic mis, acc, rdy, exp_stall, exp_req;
        int   stalls, exp_stalls;
        bit   done;
        wb_t  e;
        mis = (ld | st) & ref_mis(f3, addr);
        acc = (ld | st) & ~mis;
        RegWriteM   = ~st;
        ResultSrcM  = ld ? 2'b01 : 2'b00;
        LoadM       = ld;
        StoreM      = st;
        RD_M        = 5'(addr[4:0] ^ 5'd9);
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = addr;
        InstrM      = {17'h0, f3, 5'(addr[4:0] ^ 5'd9),
                       ld ? 7'b0000011 : st ? 7'b0100011 : 7'b0110011};
        dmem_rdata  = rdat;
        pc          = pc + 32'd4;
        stalls      = 0;
        done        = 1'b0;
        exp_stalls  = acc ? ((w < LIMIT) ? w : LIMIT) : 0;
        for (int k = 0; k < 16 && !done; k++) begin
            rdy        = (k >= w);
            dmem_ready = rdy;
            @(negedge clk);
            exp_stall = acc && !rdy && (k < LIMIT);
            exp_req   = acc && (rdy || k < LIMIT);
            check_eq("StallM",   32'(StallM),   32'(exp_stall));
            check_eq("dmem_req", 32'(dmem_req), 32'(exp_req));
            if (acc && k == 0) begin
                check_eq("dmem_addr",  dmem_addr,        addr & 32'hFFFF_FFFC);
                check_eq("dmem_we",    32'(dmem_we),     32'(st));
                check_eq("dmem_be",    32'(dmem_be),     32'(ref_be(st, f3, addr)));
                check_eq("dmem_wdata", dmem_wdata,       ref_wdata(st, f3, wd));
            end
            if (StallM) stalls++;
            e.bubble = exp_stall;
            e.rw     = exp_stall ? 1'b0 : (~st & ~mis & (acc ? (rdy || k < LIMIT) : 1'b1));
            e.rs     = ResultSrcM;
            e.rd     = RD_M;
            e.pc4    = PCPlus4M;
            e.alu    = addr;
            e.rdata  = (ld && acc && rdy) ? ref_load(f3, addr, rdat) : 32'h0;
            e.instr  = InstrM;
            e.mis    = exp_stall ? 1'b0 : mis;
            e.err    = acc && !rdy && (k >= LIMIT);
            sb.push_back(e);
            @(posedge clk);
            #1;
            compare_wb();
            if (!exp_stall) done = 1'b1;
        end
        check_eq("stall_cycles", 32'(stalls), 32'(exp_stalls));
    endtask

    task automatic idle_inputs();
        RegWriteM = 0; ResultSrcM = 0; LoadM = 0; StoreM = 0; RD_M = 0;
        PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0; InstrM = 0;
        dmem_ready = 0; dmem_rdata = 0;
    endtask

    initial begin
        idle_inputs();
        // Aligned LW presented during reset must not reach the bus.
        LoadM = 1; InstrM = 32'h0000_2003; ALU_ResultM = 32'h40;
        rst = 1'b1;
        #2;
        check_eq("rst_req",   32'(dmem_req),  32'd0);
        check_eq("rst_stall", 32'(StallM),    32'd0);
        check_eq("rst_rw",    32'(RegWriteW), 32'd0);
        check_eq("rst_pc4",   PCPlus4W,       32'd0);
        check_eq("rst_rdata", ReadDataW,      32'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(0, 1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0,         0);   // SW
        do_op(1, 0, 3'b000, 32'h203, 32'h0,         32'h80FF_1234, 0);   // LB
        do_op(1, 0, 3'b100, 32'h203, 32'h0,         32'h80FF_1234, 0);   // LBU
        do_op(1, 0, 3'b001, 32'h12,  32'h0,         32'h8001_ABCD, 3);   // LH, 3 wait cycles
        do_op(0, 1, 3'b000, 32'h7,   32'h55,        32'h0,         0);   // SB lane 3
        do_op(0, 1, 3'b001, 32'h2,   32'h0000_A5C3, 32'h0,         1);   // SH upper half
        do_op(1, 0, 3'b010, 32'h6,   32'h0,         32'h0,         0);   // misaligned LW
        do_op(0, 1, 3'b011, 32'h8,   32'h1,         32'h0,         0);   // funct3=11 store
        do_op(1, 0, 3'b010, 32'h100, 32'h0,         32'hCAFE_F00D, 100); // timeout
        do_op(0, 0, 3'b000, 32'h1234_5678, 32'h0,   32'hFFFF_FFFF, 0);   // ALU op, stray ready
        do_op(1, 0, 3'b101, 32'h2,   32'h0,         32'h8001_ABCD, 1);   // LHU
        do_op(1, 0, 3'b010, 32'h8,   32'h0,         32'h1234_5678, 0);   // LW back-to-back

        // Reset asserted while waiting on the bus.
        LoadM = 1; StoreM = 0; RegWriteM = 1; InstrM = 32'h0000_2083;
        ALU_ResultM = 32'h200; dmem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("wait_stall", 32'(StallM),   32'd1);
        check_eq("wait_req",   32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstw_req",   32'(dmem_req),  32'd0);
        check_eq("rstw_stall", 32'(StallM),    32'd0);
        check_eq("rstw_rw",    32'(RegWriteW), 32'd0);
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        do_op(1, 0, 3'b000, 32'h1,   32'h0,         32'h0000_7F00, 0);   // LB after reset

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
